// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: entry layout and event kinds.
// With TRACE_TIMESTAMP_EN defined, each entry also carries a cycle stamp.
package trace_pkg;

  localparam logic KIND_GRF = 1'b0;
  localparam logic KIND_DM  = 1'b1;

  localparam int PC_W    = 32;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int CYCLE_W = 32;

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [CYCLE_W-1:0] cycle;
`endif
    logic [PC_W-1:0]    pc;
    logic               kind;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
  } trace_entry_t;

  localparam int ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_ram.sv
// Entry storage: two synchronous write ports (port 1 lands one slot after
// port 0) and one asynchronous read port for first-word fall-through.
module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we0,
  input  logic               we1,
  input  logic [AW-1:0]      wr_ptr,
  input  trace_entry_t       wdata0,
  input  trace_entry_t       wdata1,
  input  logic [AW-1:0]      rd_ptr,
  output trace_entry_t       rdata
);

  trace_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr1;

  assign wr_ptr1 = wr_ptr + AW'(1);
  assign rdata   = mem[rd_ptr];

  // Write up to two consecutive slots per cycle; contents are not reset.
  always_ff @(posedge clk) begin
    if (we0) mem[wr_ptr]  <= wdata0;
    if (we1) mem[wr_ptr1] <= wdata1;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: records GRF and DM write events into a FIFO drained
// through a valid/ready port. Optional macro TRACE_TIMESTAMP_EN adds a
// free-running cycle counter whose value is stored with every entry.
//
// Handshake: out_valid is high whenever the FIFO holds an entry and out_* show
// the oldest one; the entry is consumed on a rising edge where out_valid and
// out_ready are both high. out_* never depend combinationally on out_ready.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 0,
  parameter int SKIP_ZERO = 1,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              pc,
  input  logic                     grf_we,
  input  logic [4:0]               grf_addr,
  input  logic [31:0]              grf_wd,
  input  logic                     dm_we,
  input  logic [31:0]              dm_addr,
  input  logic [31:0]              dm_wd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic                     out_kind,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         drop_cnt
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]              out_cycle
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = CNT_W + 1;

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [DW-1:0]    drop_sum;
  logic             g_ev, d_ev, pop, acc_g, acc_d;
  logic             we0, we1;
  int               n_ev, n_acc, n_pop, n_ovr, n_lost, free, occ;
  trace_entry_t     g_ent, d_ent, w0, w1, head;

`ifdef TRACE_TIMESTAMP_EN
  logic [CYCLE_W-1:0] cycle_q, cycle_d;

  assign cycle_d = cycle_q + 32'd1;

  // Free-running cycle counter, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_d;
  end
`endif

  // Event qualification and entry formatting for both capture channels.
  always_comb begin
    g_ev       = grf_we && !((SKIP_ZERO != 0) && (grf_addr == 5'd0));
    d_ev       = dm_we;
    g_ent      = '0;
    g_ent.pc   = pc;
    g_ent.kind = KIND_GRF;
    g_ent.addr = {27'd0, grf_addr};
    g_ent.data = grf_wd;
    d_ent      = '0;
    d_ent.pc   = pc;
    d_ent.kind = KIND_DM;
    d_ent.addr = dm_addr;
    d_ent.data = dm_wd;
`ifdef TRACE_TIMESTAMP_EN
    g_ent.cycle = cycle_q;
    d_ent.cycle = cycle_q;
`endif
  end

  // Acceptance, overwrite excess, pointer/count/drop-counter next state.
  always_comb begin
    pop   = (count_q != '0) && out_ready;
    n_pop = int'(pop);
    n_ev  = int'(g_ev) + int'(d_ev);
    free  = DEPTH - int'(count_q) + n_pop;
    acc_g = g_ev;
    acc_d = d_ev;
    if (OVERWRITE == 0) begin
      acc_g = g_ev && (free >= 1);
      acc_d = d_ev && (free >= (acc_g ? 2 : 1));
    end
    n_acc    = int'(acc_g) + int'(acc_d);
    occ      = int'(count_q) - n_pop + n_acc;
    n_ovr    = (occ > DEPTH) ? (occ - DEPTH) : 0;
    n_lost   = (n_ev - n_acc) + n_ovr;
    count_d  = CW'(occ - n_ovr);
    rd_ptr_d = rd_ptr_q + AW'(n_pop + n_ovr);
    wr_ptr_d = wr_ptr_q + AW'(n_acc);
    drop_sum = {1'b0, drop_q} + DW'(n_lost);
    drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    // The first accepted event always takes port 0 at wr_ptr.
    we0 = acc_g || acc_d;
    we1 = acc_g && acc_d;
    w0  = acc_g ? g_ent : d_ent;
    w1  = d_ent;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  trace_ram #(.DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .we0    (we0),
    .we1    (we1),
    .wr_ptr (wr_ptr_q),
    .wdata0 (w0),
    .wdata1 (w1),
    .rd_ptr (rd_ptr_q),
    .rdata  (head)
  );

  assign out_valid = (count_q != '0);
  assign out_pc    = head.pc;
  assign out_kind  = head.kind;
  assign out_addr  = head.addr;
  assign out_data  = head.data;
  assign count     = count_q;
  assign drop_cnt  = drop_q;
`ifdef TRACE_TIMESTAMP_EN
  assign out_cycle = head.cycle;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: three instances (16-deep drop, 4-deep drop,
// 4-deep overwrite) share one stimulus stream and are checked every cycle
// against a queue model, plus literal expectations from hand-worked cases.
// Covers out_cycle when TRACE_TIMESTAMP_EN is defined.
module tb_commit_trace_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic        kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } ent_t;

  logic        clk, reset;
  logic [31:0] pc, grf_wd, dm_addr, dm_wd;
  logic [4:0]  grf_addr;
  logic        grf_we, dm_we, out_ready;

  logic        ov [3];
  logic        okind [3];
  logic [31:0] opc [3];
  logic [31:0] oaddr [3];
  logic [31:0] odata [3];
  logic [31:0] ocyc [3];
  logic [31:0] ocnt [3];
  logic [15:0] odrop [3];
  logic [4:0]  c0;
  logic [2:0]  c1, c2;

  ent_t        mq [3][16];
  int          mcnt [3];
  int          mdrop [3];
  logic [31:0] mcyc;
  int          n_chk, n_fail;

  assign ocnt[0] = 32'(c0);
  assign ocnt[1] = 32'(c1);
  assign ocnt[2] = 32'(c2);
`ifndef TRACE_TIMESTAMP_EN
  assign ocyc[0] = '0;
  assign ocyc[1] = '0;
  assign ocyc[2] = '0;
`endif

  commit_trace_buffer #(.DEPTH(16), .OVERWRITE(0)) dut0 (
    .clk(clk), .reset(reset), .pc(pc), .grf_we(grf_we), .grf_addr(grf_addr),
    .grf_wd(grf_wd), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
    .out_valid(ov[0]), .out_ready(out_ready), .out_pc(opc[0]), .out_kind(okind[0]),
    .out_addr(oaddr[0]), .out_data(odata[0]), .count(c0), .drop_cnt(odrop[0])
`ifdef TRACE_TIMESTAMP_EN
    , .out_cycle(ocyc[0])
`endif
  );

  commit_trace_buffer #(.DEPTH(4), .OVERWRITE(0)) dut1 (
    .clk(clk), .reset(reset), .pc(pc), .grf_we(grf_we), .grf_addr(grf_addr),
    .grf_wd(grf_wd), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
    .out_valid(ov[1]), .out_ready(out_ready), .out_pc(opc[1]), .out_kind(okind[1]),
    .out_addr(oaddr[1]), .out_data(odata[1]), .count(c1), .drop_cnt(odrop[1])
`ifdef TRACE_TIMESTAMP_EN
    , .out_cycle(ocyc[1])
`endif
  );

  commit_trace_buffer #(.DEPTH(4), .OVERWRITE(1)) dut2 (
    .clk(clk), .reset(reset), .pc(pc), .grf_we(grf_we), .grf_addr(grf_addr),
    .grf_wd(grf_wd), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
    .out_valid(ov[2]), .out_ready(out_ready), .out_pc(opc[2]), .out_kind(okind[2]),
    .out_addr(oaddr[2]), .out_data(odata[2]), .count(c2), .drop_cnt(odrop[2])
`ifdef TRACE_TIMESTAMP_EN
    , .out_cycle(ocyc[2])
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep(int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic bit ovw(int i);
    return (i == 2);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic remove_head(int i);
    for (int j = 0; j < 15; j++) mq[i][j] = mq[i][j+1];
    mcnt[i]--;
  endtask

  task automatic add_drop(int i, int n);
    mdrop[i] = (mdrop[i] + n > 65535) ? 65535 : mdrop[i] + n;
  endtask

  // Queue model: pop first, then append events in order; a full queue either
  // loses the new event or discards its oldest entry.
  task automatic model_step();
    ent_t ev [2];
    int   nev;
    nev = 0;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        mcnt[i]  = 0;
        mdrop[i] = 0;
      end
      mcyc = '0;
      return;
    end
    if (grf_we && grf_addr != 5'd0) begin
      ev[nev].pc = pc; ev[nev].kind = 1'b0; ev[nev].addr = {27'd0, grf_addr};
      ev[nev].data = grf_wd; ev[nev].cyc = mcyc;
      nev = nev + 1;
    end
    if (dm_we) begin
      ev[nev].pc = pc; ev[nev].kind = 1'b1; ev[nev].addr = dm_addr;
      ev[nev].data = dm_wd; ev[nev].cyc = mcyc;
      nev = nev + 1;
    end
    for (int i = 0; i < 3; i++) begin
      if (out_ready && mcnt[i] > 0) remove_head(i);
      for (int e = 0; e < nev; e++) begin
        if (mcnt[i] == dep(i)) begin
          add_drop(i, 1);
          if (ovw(i)) begin
            remove_head(i);
            mq[i][mcnt[i]] = ev[e];
            mcnt[i]++;
          end
        end else begin
          mq[i][mcnt[i]] = ev[e];
          mcnt[i]++;
        end
      end
    end
    mcyc = mcyc + 32'd1;
  endtask

  // Compare every instance against the model.
  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("valid%0d", i), 32'(ov[i]), 32'(mcnt[i] > 0));
      chk($sformatf("count%0d", i), ocnt[i], mcnt[i]);
      chk($sformatf("drop%0d", i), 32'(odrop[i]), mdrop[i]);
      if (mcnt[i] > 0) begin
        chk($sformatf("pc%0d", i), opc[i], mq[i][0].pc);
        chk($sformatf("kind%0d", i), 32'(okind[i]), 32'(mq[i][0].kind));
        chk($sformatf("addr%0d", i), oaddr[i], mq[i][0].addr);
        chk($sformatf("data%0d", i), odata[i], mq[i][0].data);
`ifdef TRACE_TIMESTAMP_EN
        chk($sformatf("cycle%0d", i), ocyc[i], mq[i][0].cyc);
`endif
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic gw, input logic [4:0] ga, input logic [31:0] gd,
                       input logic dw, input logic [31:0] da, input logic [31:0] dd,
                       input logic rdy, input logic [31:0] p);
    grf_we = gw; grf_addr = ga; grf_wd = gd;
    dm_we = dw; dm_addr = da; dm_wd = dd;
    out_ready = rdy; pc = p;
    tick();
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, rdy, 32'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; mcyc = '0;
    for (int i = 0; i < 3; i++) begin mcnt[i] = 0; mdrop[i] = 0; end
    reset = 1'b1;
    grf_we = 0; grf_addr = 0; grf_wd = 0; dm_we = 0; dm_addr = 0; dm_wd = 0;
    out_ready = 0; pc = 0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_count", ocnt[0], 32'd0);
    chk("rst_valid", 32'(ov[0]), 32'd0);
    chk("rst_drop", 32'(odrop[2]), 32'd0);

    // Single GRF write, then pop.
    drive(1, 5'd8, 32'h1234, 0, 0, 0, 0, 32'h3000);
    chk("t1_valid", 32'(ov[0]), 32'd1);
    chk("t1_kind", 32'(okind[0]), 32'd0);
    chk("t1_addr", oaddr[0], 32'd8);
    chk("t1_data", odata[0], 32'h1234);
    chk("t1_count", ocnt[0], 32'd1);
    idle(1, 1);
    chk("t1_pop_count", ocnt[0], 32'd0);
    chk("t1_pop_valid", 32'(ov[0]), 32'd0);

    // Dual event: GRF before DM.
    drive(1, 5'd3, 32'd5, 1, 32'h10, 32'd7, 0, 32'h3004);
    chk("t2_count", ocnt[0], 32'd2);
    chk("t2_head_addr", oaddr[0], 32'd3);
    chk("t2_head_data", odata[0], 32'd5);
    idle(1, 1);
    chk("t2_second_kind", 32'(okind[0]), 32'd1);
    chk("t2_second_addr", oaddr[0], 32'h10);
    chk("t2_second_data", odata[0], 32'd7);
    idle(1, 1);

    // Write to $0 is not recorded and not counted as dropped.
    drive(1, 5'd0, 32'hdead, 0, 0, 0, 0, 32'h3008);
    chk("t3_count", ocnt[0], 32'd0);
    chk("t3_drop", 32'(odrop[0]), 32'd0);

    // Fill four, then dual events with and without a pop.
    for (int k = 0; k < 4; k++) drive(1, 5'(k + 1), k, 0, 0, 0, 0, 32'h100 + 4 * k);
    drive(1, 5'd9, 32'haa, 1, 32'h20, 32'hbb, 0, 32'h200);
    chk("t4_drop_d4", 32'(odrop[1]), 32'd2);
    chk("t4_count_d4", ocnt[1], 32'd4);
    chk("t4_drop_ow", 32'(odrop[2]), 32'd2);
    drive(1, 5'd10, 32'hcc, 1, 32'h24, 32'hdd, 1, 32'h204);
    chk("t4b_drop_d4", 32'(odrop[1]), 32'd3);
    chk("t4b_count_d4", ocnt[1], 32'd4);
    chk("t4b_head_d4", opc[1], 32'h104);
    chk("t4b_head_ow", opc[2], 32'h200);
    chk("t4b_drop_ow", 32'(odrop[2]), 32'd3);
    idle(1, 12);

    // Reset with entries queued, then timestamps at cycles 3 and 7.
    drive(1, 5'd1, 32'd1, 0, 0, 0, 0, 32'h400);
    drive(1, 5'd2, 32'd2, 0, 0, 0, 0, 32'h404);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rst_count", ocnt[0], 32'd0);
    chk("t5_rst_valid", 32'(ov[0]), 32'd0);
    idle(0, 3);
    drive(1, 5'd4, 32'h44, 0, 0, 0, 0, 32'h500);
    idle(0, 3);
    drive(1, 5'd5, 32'h55, 0, 0, 0, 0, 32'h504);
`ifdef TRACE_TIMESTAMP_EN
    chk("t5_cycle_a", ocyc[0], 32'd3);
    idle(1, 1);
    chk("t5_cycle_b", ocyc[0], 32'd7);
`endif
    idle(1, 4);

    // Six single events with no pops.
    for (int k = 0; k < 6; k++) drive(1, 5'd1, k, 0, 0, 0, 0, k);
    chk("t6_count_ow", ocnt[2], 32'd4);
    chk("t6_head_ow", opc[2], 32'd2);
    chk("t6_drop_ow", 32'(odrop[2]), 32'd2);
    chk("t6_drop_d4", 32'(odrop[1]), 32'd2);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t6_drain%0d", k), opc[2], 32'(2 + k));
      idle(1, 1);
    end
    idle(1, 4);

    // Mixed traffic including $0 writes and intermittent reads.
    for (int k = 0; k < 80; k++)
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
            1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 2) == 0), 32'h1000 + 4 * k);
    idle(1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable successor to the simulation-only instruction print probe. Captures architectural commit events (GRF write, DM write) from the CPU into a parametrised on-chip FIFO.
- Drained through a valid/ready port by a UART/debug reader or the bench.
- Sits beside the mips top. Taps the GRF write port and the DM write port plus the committing PC.
- Supports two write channels per cycle and a selectable full-buffer policy.

Parameters:
- DEPTH, 16: entries; power of 2, at least 4.
- OVERWRITE, 0: 0 = drop new events when full; 1 = overwrite oldest.
- SKIP_ZERO, 1: 1 = GRF writes to $0 are not recorded.
- CNT_W, 16: width of drop counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- pc  in  32  PC of committing instruction.
- grf_we  in  1  GRF write this cycle.
- grf_addr  in  5  GRF destination.
- grf_wd  in  32  GRF write data.
- dm_we  in  1  DM write this cycle.
- dm_addr  in  32  DM byte address.
- dm_wd  in  32  DM write data.
- out_valid  out  1  head entry available.
- out_ready  in  1  reader accepts head.
- out_pc  out  32  head PC.
- out_kind  out  1  0 = GRF, 1 = DM.
- out_addr  out  32  register number (zero-extended) or DM address.
- out_data  out  32  written value.
- count  out  $clog2(DEPTH)+1  occupied entries.
- drop_cnt  out  CNT_W  events lost.

Behaviour:
- Reset: count=0, out_valid=0, pointers=0, drop_cnt=0; stored entries are don't-care. Reset mid-drain discards all entries.
- Event qualification:
  - g_ev = grf_we && !(SKIP_ZERO && grf_addr==0).
  - d_ev = dm_we.
  - Both may assert in one cycle. GRF is pushed first, DM second.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately.
- Output: first-word fall-through. out_* is combinational from array[rd_ptr]; out_valid = (count!=0). Pop occurs when out_valid && out_ready.
- Write latency: an event pushed at edge N is visible on out_* after edge N, i.e. at the earliest one cycle later.
- Drop mode (OVERWRITE=0):
  - free = DEPTH - count + pop. A pop in the same cycle frees its slot.
  - Accept min(free, g_ev+d_ev) events in priority order GRF then DM.
  - drop_cnt += rejected events, saturating at all-ones.
- Overwrite mode (OVERWRITE=1):
  - All events are always accepted.
  - If count - pop + pushes > DEPTH, rd_ptr advances by the excess and count saturates at DEPTH.
  - drop_cnt += excess, saturating.
  - Simultaneous pop and overwrite: the excess is computed after the pop, so the popped entry counts as consumed, not dropped.
- Count update: count_next = count + accepted - pop - overwritten. count never exceeds DEPTH.
- Empty with out_ready=1: no pop, no pointer change.

Optional Feature:
- TRACE_TIMESTAMP_EN defined:
  - Adds a 32-bit free-running cycle counter, reset to 0, incremented every cycle with wrap.
  - Each entry stores the counter value at push. Both events of one cycle share the same stamp.
  - Adds port out_cycle, out, 32.
- Undefined: no counter, no port, no storage.

Decomposition:
- Package trace_pkg:
  - KIND_GRF=1'b0, KIND_DM=1'b1.
  - Entry field widths.
  - Packed entry typedef trace_entry_t (pc, kind, addr, data, optional cycle).
- One sub-module: trace_ram, a DEPTH x entry-width array with two synchronous write ports (second port at wr_ptr+1) and one asynchronous read port.
- The control logic (pointers, count, drop policy) stays in the top.

Test Plan:
- Reset then single GRF write pc=0x3000, $8<=0x1234 -> next cycle out_valid=1, kind=0, addr=8, data=0x1234, count=1. Pop -> count=0, out_valid=0.
- Same cycle grf $3<=5 and dm 0x10<=7, pc=0x3004 -> two entries in order GRF then DM, count=2.
- SKIP_ZERO=1, grf_addr=0 -> nothing recorded, drop_cnt unchanged.
- DEPTH=4, OVERWRITE=0: fill 4, then dual event with no pop -> drop_cnt=2, count=4. Repeat with pop asserted -> GRF accepted, DM dropped, drop_cnt=3.
- DEPTH=4, OVERWRITE=1: push 6 single events pc=0..5, no pops -> count=4, head pc=2, drop_cnt=2. Drain yields pc 2,3,4,5.
- TRACE_TIMESTAMP_EN: reset, events at cycles 3 and 7 -> out_cycle 3 then 7. Assert reset while 2 entries are queued -> next cycle count=0, out_valid=0.
